// File: rtl/mips_pkg.sv
// mips_pkg: state encodings, ALU codes, opcode/funct constants and the latched instruction class
package mips_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_IMM_EX   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ILLEGAL  = 4'd15
  } state_t;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_EQ  = 4'b1111;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  typedef struct packed {
    logic [3:0] alu_op;
    logic       ext_sel;
    logic       is_r;
    logic       is_sw;
    logic       is_bne;
  } cls_t;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps op/funct to ALU code, immediate extension and a legal-instruction flag
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       ext_sel,
  output logic       legal
);
  // per-opcode ALU code; R-type refines through funct
  always_comb begin
    alu_op = ALU_ADD;
    ext_sel = 1'b0;
    legal = 1'b1;
    case (op)
      OP_R:
        case (funct)
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_SLT:          alu_op = ALU_SLT;
          FN_NOR:          alu_op = ALU_NOR;
          default:         legal = 1'b0;
        endcase
      OP_ANDI: begin
        alu_op = ALU_AND;
        ext_sel = 1'b1;
      end
      OP_ORI: begin
        alu_op = ALU_OR;
        ext_sel = 1'b1;
      end
      OP_SLTI:                   alu_op = ALU_SLT;
      OP_BEQ, OP_BNE:            alu_op = ALU_SUB;
      OP_LW, OP_SW, OP_ADDI, OP_J: alu_op = ALU_ADD;
      default:                   legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle MIPS control FSM driving datapath selects, enables and ALU code
module mips_mc_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       iord,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sel,
  output logic [1:0] pc_src,
  output logic [3:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);
  state_t state_q, st, nxt;
  cls_t cls_q;
  logic illegal_q;
  logic [3:0] dec_op;
  logic dec_ext, dec_legal;
  alu_decoder u_dec (
    .op(op),
    .funct(funct),
    .alu_op(dec_op),
    .ext_sel(dec_ext),
    .legal(dec_legal)
  );
  assign st = reset ? S_FETCH : state_q;
  assign state = state_q;
  // state register; class is captured while in DECODE, illegal sticks until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cls_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= nxt;
      if (state_q == S_DECODE)
        cls_q <= '{alu_op: dec_op, ext_sel: dec_ext, is_r: op == OP_R, is_sw: op == OP_SW, is_bne: op == OP_BNE};
      if (nxt == S_ILLEGAL) illegal_q <= 1'b1;
    end
  end
  // next state and outputs; reset views the FSM as FETCH with PC/IR writes suppressed
  always_comb begin
    nxt = st;
    pc_wr = 1'b0;
    ir_wr = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    iord = 1'b0;
    reg_wr = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    ext_sel = 1'b0;
    pc_src = 2'b00;
    alu_op = ALU_AND;
    illegal = illegal_q & ~reset;
    case (st)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
          alu_src_b = 2'b01;
          alu_op = ALU_ADD;
          nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op = ALU_ADD;
        nxt = !dec_legal ? S_ILLEGAL :
              (op == OP_LW || op == OP_SW) ? S_MEMADR :
              op == OP_R ? S_RTYPE_EX :
              (op == OP_BEQ || op == OP_BNE) ? S_BRANCH :
              op == OP_J ? S_JUMP : S_IMM_EX;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op = ALU_ADD;
        nxt = cls_q.is_sw ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_rd = 1'b1;
        iord = 1'b1;
        nxt = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_wr = 1'b1;
        mem_to_reg = 1'b1;
        nxt = S_FETCH;
      end
      S_MEMWR: begin
        mem_wr = 1'b1;
        iord = 1'b1;
        nxt = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op = cls_q.alu_op;
        nxt = S_ALU_WB;
      end
      S_IMM_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_sel = cls_q.ext_sel;
        alu_op = cls_q.alu_op;
        nxt = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_wr = 1'b1;
        reg_dst = cls_q.is_r;
        nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = ALU_SUB;
        pc_src = 2'b01;
        pc_wr = cls_q.is_bne ? ~zero : zero;
        nxt = S_FETCH;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_wr = 1'b1;
        nxt = S_FETCH;
      end
      S_ILLEGAL: nxt = S_ILLEGAL;
      default: nxt = S_ILLEGAL;
    endcase
    if (reset) begin
      pc_wr = 1'b0;
      ir_wr = 1'b0;
    end
  end
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: randomized instruction stream checked against a per-instruction reference model
module tb_mips_mc_control;
  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [5:0] op, funct;
  logic pc_wr, ir_wr, mem_rd, mem_wr, iord, reg_wr, reg_dst, mem_to_reg, alu_src_a, ext_sel, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_op, state;
  logic [22:0] obs;
  int n_chk = 0;
  int n_fail = 0;
  int force_wait = 0;
  int wait_st = -1;
  int force_zero = -1;
  int abort_st = -1;
  logic [5:0] ops [10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h02};
  logic [5:0] fns [8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
  always #5 clk = ~clk;
  mips_mc_control dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord),
    .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_sel(ext_sel), .pc_src(pc_src), .alu_op(alu_op),
    .illegal(illegal), .state(state)
  );
  assign obs = {pc_wr, ir_wr, mem_rd, mem_wr, iord, reg_wr, reg_dst, mem_to_reg, alu_src_a,
                alu_src_b, ext_sel, pc_src, alu_op, illegal, state};

  task automatic check(string tag, logic [22:0] got, logic [22:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit legal_instr(logic [5:0] o, logic [5:0] f);
    if (o == 6'h00) return f inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
    return o inside {6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h02};
  endfunction

  function automatic logic [3:0] ref_alu(logic [5:0] o, logic [5:0] f);
    if (o == 6'h00)
      return f == 6'h24 ? 4'b0000 : f == 6'h25 ? 4'b0001 : (f == 6'h22 || f == 6'h23) ? 4'b0110 :
             f == 6'h2A ? 4'b0111 : f == 6'h27 ? 4'b1100 : 4'b0010;
    return o == 6'h0C ? 4'b0000 : o == 6'h0D ? 4'b0001 : o == 6'h0A ? 4'b0111 : 4'b0010;
  endfunction

  function automatic logic [22:0] ref_ctl(int st, logic r, logic z, logic [5:0] o, logic [5:0] f);
    logic pcw, irw, mr, mw, io, rw, rd, m2r, sa, es;
    logic [1:0] sb, ps;
    logic [3:0] ao;
    {pcw, irw, mr, mw, io, rw, rd, m2r, sa, es, sb, ps, ao} = '0;
    if (st == 0) begin
      mr = 1;
      if (r) begin irw = 1; pcw = 1; sb = 2'b01; ao = 4'b0010; end
    end
    if (st == 1) begin sb = 2'b11; ao = 4'b0010; end
    if (st == 2) begin sa = 1; sb = 2'b10; ao = 4'b0010; end
    if (st == 3) begin mr = 1; io = 1; end
    if (st == 4) begin rw = 1; m2r = 1; end
    if (st == 5) begin mw = 1; io = 1; end
    if (st == 6) begin sa = 1; ao = ref_alu(o, f); end
    if (st == 7) begin sa = 1; sb = 2'b10; ao = ref_alu(o, f); es = o inside {6'h0C, 6'h0D}; end
    if (st == 8) begin rw = 1; rd = o == 6'h00; end
    if (st == 9) begin sa = 1; ao = 4'b0110; ps = 2'b01; pcw = o == 6'h04 ? z : ~z; end
    if (st == 10) begin ps = 2'b10; pcw = 1; end
    return {pcw, irw, mr, mw, io, rw, rd, m2r, sa, sb, es, ps, ao, 1'(st == 15), 4'(st)};
  endfunction

  function automatic logic [22:0] ref_reset(int cur, logic r, logic z);
    logic [22:0] e;
    e = ref_ctl(0, r, z, 6'h00, 6'h00);
    e[22:21] = 2'b00;
    e[3:0] = 4'(cur);
    return e;
  endfunction

  task automatic do_reset(int cur);
    reset = 1;
    mem_ready = 1'($urandom_range(0, 1));
    zero = 1'($urandom_range(0, 1));
    op = 6'($urandom);
    funct = 6'($urandom);
    @(negedge clk);
    check("reset_hold", obs, ref_reset(cur, mem_ready, zero));
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic run_instr(logic [5:0] o, logic [5:0] f);
    int seq[$];
    seq = {0, 1};
    if (!legal_instr(o, f)) seq.push_back(15);
    else if (o == 6'h23) seq = {seq, 2, 3, 4};
    else if (o == 6'h2B) seq = {seq, 2, 5};
    else if (o == 6'h00) seq = {seq, 6, 8};
    else if (o inside {6'h04, 6'h05}) seq.push_back(9);
    else if (o == 6'h02) seq.push_back(10);
    else seq = {seq, 7, 8};
    foreach (seq[k]) begin
      int st = seq[k];
      int w = 0;
      forever begin
        logic r, z;
        r = force_wait < 0 ? ($urandom_range(0, 3) != 0) : (st == wait_st ? (w >= force_wait) : 1'b1);
        z = force_zero >= 0 ? force_zero[0] : 1'($urandom_range(0, 1));
        op = st == 1 ? o : 6'($urandom);
        funct = st == 1 ? f : 6'($urandom);
        mem_ready = r;
        zero = z;
        if (st == abort_st && w == 1) begin
          reset = 1;
          mem_ready = 1;
          @(negedge clk);
          check("reset_mid", obs, ref_reset(st, 1'b1, z));
          @(posedge clk); #1;
          reset = 0;
          abort_st = -1;
          return;
        end
        @(negedge clk);
        check($sformatf("op%02h_fn%02h_st%0d_w%0d", o, f, st, w), obs, ref_ctl(st, r, z, o, f));
        @(posedge clk); #1;
        w++;
        if (st == 15 ? w == 10 : (!(st inside {0, 3, 5}) || r)) break;
      end
    end
  endtask

  initial begin
    reset = 1; mem_ready = 0; zero = 0; op = 0; funct = 0;
    @(posedge clk); #1;
    do_reset(0);
    run_instr(6'h00, 6'h22);
    wait_st = 3; force_wait = 2;
    run_instr(6'h23, 6'h11);
    wait_st = -1; force_wait = 0; force_zero = 1;
    run_instr(6'h04, 6'h00);
    run_instr(6'h05, 6'h00);
    force_zero = -1;
    run_instr(6'h0D, 6'h3C);
    run_instr(6'h3F, 6'h00);
    do_reset(15);
    run_instr(6'h00, 6'h01);
    do_reset(15);
    wait_st = 3; force_wait = 5; abort_st = 3;
    run_instr(6'h23, 6'h00);
    wait_st = -1; force_wait = -1;
    for (int i = 0; i < 300; i++) begin
      logic [5:0] o, f;
      o = ops[$urandom_range(0, 9)];
      f = o == 6'h00 ? fns[$urandom_range(0, 7)] : 6'($urandom);
      if ($urandom_range(0, 15) == 0) o = 6'($urandom);
      if ($urandom_range(0, 15) == 0) f = 6'($urandom);
      run_instr(o, f);
      if (!legal_instr(o, f)) do_reset(15);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multicycle control unit for the MIPS datapath. It decodes the instruction register's opcode and funct fields through a registered state machine and drives every datapath select, write enable and the 4-bit `Alu_Op` code consumed by the ALU. It sits directly upstream of the ALU and samples the ALU zero flag to resolve branches. One instruction is in flight at a time, and memory accesses use a ready handshake.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `op` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU Z flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_wr` out 1: PC write enable.
- `ir_wr` out 1: IR load.
- `mem_rd` out 1: memory read request.
- `mem_wr` out 1: memory write request.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `reg_wr` out 1: register-file write.
- `reg_dst` out 1: 0 = rt, 1 = rd.
- `mem_to_reg` out 1: 0 = ALUOut, 1 = MDR.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 2: 00 = B, 01 = 4, 10 = ext(imm), 11 = sext(imm)<<2.
- `ext_sel` out 1: 0 = sign-extend, 1 = zero-extend.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_op` out 4: ALU operation code.
- `illegal` out 1: sticky unsupported-opcode flag.
- `state` out 4: current state, for debug.

## Operation
- **ALU codes:** AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, EQ 1111.
- **Supported R-type (op 0x00):** funct 0x24 AND, 0x25 OR, 0x20/0x21 ADD, 0x22/0x23 SUB, 0x2A SLT, 0x27 NOR. Any other funct is illegal.
- **Supported I/J-type:** lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08 (ADD, sign-ext), andi 0x0C (AND, zero-ext), ori 0x0D (OR, zero-ext), slti 0x0A (SLT, sign-ext), j 0x02.
- **FETCH:** mem_rd=1, iord=0. When mem_ready=1: ir_wr=1, pc_wr=1, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00, then go to DECODE. Otherwise stay in FETCH.
- **DECODE:** alu_src_a=0, alu_src_b=11, alu_op=ADD to compute the branch target into ALUOut. Dispatch on op to MEMADR, RTYPE_EX, IMM_EX, BRANCH, JUMP, or ILLEGAL.
- **MEMADR:** alu_src_a=1, alu_src_b=10, ext_sel=0, alu_op=ADD. lw goes to MEMRD; sw goes to MEMWR.
- **MEMRD:** mem_rd=1, iord=1. Wait for mem_ready, then go to MEMWB.
- **MEMWB:** reg_wr=1, reg_dst=0, mem_to_reg=1, then go to FETCH.
- **MEMWR:** mem_wr=1, iord=1. Wait for mem_ready, then go to FETCH.
- **RTYPE_EX:** alu_src_a=1, alu_src_b=00, alu_op from funct, then go to ALU_WB.
- **IMM_EX:** alu_src_a=1, alu_src_b=10, ext_sel and alu_op from op, then go to ALU_WB.
- **ALU_WB:** reg_wr=1, mem_to_reg=0, reg_dst=1 for R-type and 0 for I-type, then go to FETCH.
- **BRANCH:** alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01. pc_wr = zero for beq, and ~zero for bne. Go to FETCH.
- **JUMP:** pc_src=10, pc_wr=1, then go to FETCH.
- **ILLEGAL:** all enables 0, illegal=1. The state holds until reset.
- **Instruction class latch:** needed after DECODE (lw/sw, R/I, beq/bne). It is latched from op/funct on the DECODE cycle.
- **Defaults:** every output not listed for a state is 0.

## Timing
- **State updates:** registered on the rising clk edge.
- **Outputs:** combinational from the state register, the latched class, and `zero` (BRANCH only).
- **Reset:** reset=1 at an edge forces FETCH and clears the class latch and illegal. This takes priority at any state, including mid-handshake.
- **Outputs during reset:** while reset is held, outputs take FETCH values, with ir_wr=pc_wr=0 forced.
- **Cycle counts with mem_ready always 1:** R/I-ALU 4, lw 5, sw 4, beq/bne 3, j 3.
- **Wait states:** each cycle with mem_ready=0 adds exactly one cycle and holds all outputs stable.
- **mem_ready outside a memory state:** ignored.

## Structure
- **mips_pkg:** state encodings (FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPE_EX=6, IMM_EX=7, ALU_WB=8, BRANCH=9, JUMP=10, ILLEGAL=15), the ALU op codes, and the opcode/funct constants.
- **alu_decoder:** combinational sub-module. Maps op/funct to alu_op, ext_sel and a legal flag.

## Test plan
- **Reset:** reset mid-MEMRD → next state FETCH, mem_rd=1, pc_wr=0 while reset is held, illegal=0.
- **R-type:** op=0x00, funct=0x22, mem_ready=1 → states 0,1,6,8. alu_op=0110 in RTYPE_EX; reg_wr=1 and reg_dst=1 on cycle 4.
- **lw with wait:** lw with mem_ready low for 2 cycles in MEMRD → 7 total cycles, mem_rd and iord stable through the wait, mem_to_reg=1 in MEMWB.
- **Branches:** beq with zero=1 → pc_wr=1, pc_src=01 in BRANCH. bne with zero=1 → pc_wr=0.
- **Zero-extend immediate:** ori 0x0D → ext_sel=1, alu_op=0001, alu_src_b=10; then reg_wr=1, reg_dst=0.
- **Illegal opcode:** op=0x3F → ILLEGAL and illegal=1, with no writes for 10 cycles. reset then recovers to FETCH.
